// File: rtl/jtag_clk_tap.sv
// JTAG TAP controller clocked entirely by the system clock: tck/tms/tdi are oversampled
// and user data registers are reached through a variable-length capture/update handshake.
module jtag_clk_tap #(
    parameter int              IR_W         = 5,
    parameter int              DR_W         = 96,
    parameter int              LEN_W        = 7,
    parameter int              ID_W         = 40,
    parameter logic [IR_W-1:0] IDCODE_INSTR = '0,
    parameter logic [IR_W-1:0] BYPASS_INSTR = '1,
    parameter int              SYNC_STAGES  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tck,
    input  logic             tms,
    input  logic             tdi,
    output logic             tdo,
    input  logic [ID_W-1:0]  id,
    output logic [IR_W-1:0]  ir,
    output logic [3:0]       jstate,
    output logic             reg_rd_req,
    input  logic             reg_rd_ack,
    input  logic [DR_W-1:0]  reg_rd_data,
    input  logic [LEN_W-1:0] reg_len,
    output logic             reg_wr_stb,
    output logic [DR_W-1:0]  reg_wr_data,
    output logic             capture_err
);

    localparam int SR_W = (DR_W > ID_W) ? DR_W : ID_W;
    localparam int CL_W = $clog2(SR_W + 1);

    typedef enum logic [3:0] {
        TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
        SH_DR  = 4'd4,  EX1_DR = 4'd5,  PS_DR  = 4'd6,  EX2_DR = 4'd7,
        UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
        EX1_IR = 4'd12, PS_IR  = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
    } tap_state_t;

    tap_state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
    logic                   tck_d;
    logic                   tck_s, tms_s, tdi_s, rise, fall;

    logic [IR_W-1:0]  ir_sr;
    logic [SR_W-1:0]  dr, dr_shift, wr_mask, cap_mask;
    logic [CL_W-1:0]  cur_len, cap_len;
    logic             rd_pending, ack_seen, ack_take, have_ack, req_fire;
    logic [DR_W-1:0]  rd_buf, cap_data;
    logic [LEN_W-1:0] rd_len, cap_len_raw;
    logic             is_idcode, is_bypass, is_user;

    function automatic logic [SR_W-1:0] len_mask(input logic [CL_W-1:0] n);
        logic [SR_W-1:0] m;
        m = '0;
        for (int i = 0; i < SR_W; i++) m[i] = (i < int'(n));
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
            tck_d    <= 1'b0;
        end else begin
            tck_sync <= {tck_sync[SYNC_STAGES-2:0], tck};
            tms_sync <= {tms_sync[SYNC_STAGES-2:0], tms};
            tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], tdi};
            tck_d    <= tck_sync[SYNC_STAGES-1];
        end
    end

    assign tck_s = tck_sync[SYNC_STAGES-1];
    assign tms_s = tms_sync[SYNC_STAGES-1];
    assign tdi_s = tdi_sync[SYNC_STAGES-1];
    assign rise  = tck_s & ~tck_d;
    assign fall  = ~tck_s & tck_d;

    assign is_idcode = (ir == IDCODE_INSTR);
    assign is_bypass = (ir == BYPASS_INSTR);
    assign is_user   = !is_idcode && !is_bypass;
    assign jstate    = ~state_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= TLR;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (rise) begin
            case (state_q)
                TLR:     state_d = tms_s ? TLR    : RTI;
                RTI:     state_d = tms_s ? SEL_DR : RTI;
                SEL_DR:  state_d = tms_s ? SEL_IR : CAP_DR;
                CAP_DR:  state_d = tms_s ? EX1_DR : SH_DR;
                SH_DR:   state_d = tms_s ? EX1_DR : SH_DR;
                EX1_DR:  state_d = tms_s ? UPD_DR : PS_DR;
                PS_DR:   state_d = tms_s ? EX2_DR : PS_DR;
                EX2_DR:  state_d = tms_s ? UPD_DR : SH_DR;
                UPD_DR:  state_d = tms_s ? SEL_DR : RTI;
                SEL_IR:  state_d = tms_s ? TLR    : CAP_IR;
                CAP_IR:  state_d = tms_s ? EX1_IR : SH_IR;
                SH_IR:   state_d = tms_s ? EX1_IR : SH_IR;
                EX1_IR:  state_d = tms_s ? UPD_IR : PS_IR;
                PS_IR:   state_d = tms_s ? EX2_IR : PS_IR;
                EX2_IR:  state_d = tms_s ? UPD_IR : SH_IR;
                UPD_IR:  state_d = tms_s ? SEL_DR : RTI;
                default: state_d = TLR;
            endcase
        end
    end

    // An ack landing in the same clk as the capture edge still counts as on time.
    assign ack_take    = reg_rd_ack && rd_pending;
    assign have_ack    = ack_seen || ack_take;
    assign cap_data    = ack_take ? reg_rd_data : rd_buf;
    assign cap_len_raw = ack_take ? reg_len : rd_len;
    assign req_fire    = rise && (state_q == SEL_DR) && !tms_s && is_user;

    // Out-of-range lengths are treated as a full-width register rather than a 0-bit one.
    always_comb begin
        cap_len = CL_W'(cap_len_raw);
        if (cap_len_raw == '0 || int'(cap_len_raw) > DR_W) cap_len = CL_W'(DR_W);
        cap_mask = len_mask(cap_len);
        wr_mask  = len_mask(cur_len);
    end

    always_comb begin
        logic [SR_W-1:0] dr_hi;
        dr_hi    = dr >> 1;
        dr_shift = '0;
        for (int i = 0; i < SR_W; i++) begin
            if (i == int'(cur_len) - 1)    dr_shift[i] = tdi_s;
            else if (i < int'(cur_len) - 1) dr_shift[i] = dr_hi[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pending <= 1'b0;
            ack_seen   <= 1'b0;
            rd_buf     <= '0;
            rd_len     <= '0;
        end else begin
            if (ack_take) begin
                ack_seen   <= 1'b1;
                rd_pending <= 1'b0;
                rd_buf     <= reg_rd_data;
                rd_len     <= reg_len;
            end
            if (req_fire) begin
                rd_pending <= 1'b1;
                ack_seen   <= 1'b0;
            end else if (rise && state_q == CAP_DR) begin
                rd_pending <= 1'b0;
            end
        end
    end

    // TLR holds ir at IDCODE every clk, so the instruction is restored as soon as TLR is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir          <= IDCODE_INSTR;
            ir_sr       <= '0;
            dr          <= '0;
            cur_len     <= CL_W'(ID_W);
            tdo         <= 1'b0;
            reg_rd_req  <= 1'b0;
            reg_wr_stb  <= 1'b0;
            reg_wr_data <= '0;
            capture_err <= 1'b0;
        end else begin
            reg_rd_req <= req_fire;
            reg_wr_stb <= 1'b0;
            if (state_q == TLR) ir <= IDCODE_INSTR;
            if (rise) begin
                case (state_q)
                    CAP_IR: ir_sr <= ir;
                    SH_IR:  ir_sr <= {tdi_s, ir_sr[IR_W-1:1]};
                    UPD_IR: ir    <= ir_sr;
                    CAP_DR: begin
                        if (is_idcode) begin
                            dr      <= SR_W'(id);
                            cur_len <= CL_W'(ID_W);
                        end else if (is_bypass) begin
                            dr      <= '0;
                            cur_len <= CL_W'(1);
                        end else if (have_ack) begin
                            dr      <= SR_W'(cap_data) & cap_mask;
                            cur_len <= cap_len;
                        end else begin
                            dr          <= '0;
                            cur_len     <= CL_W'(DR_W);
                            capture_err <= 1'b1;
                        end
                    end
                    SH_DR:  dr <= dr_shift;
                    UPD_DR: begin
                        if (is_user) begin
                            reg_wr_stb  <= 1'b1;
                            reg_wr_data <= dr[DR_W-1:0] & wr_mask[DR_W-1:0];
                        end
                    end
                    default: ;
                endcase
            end
            if (fall) begin
                if (state_q == SH_IR)      tdo <= ir_sr[0];
                else if (state_q == SH_DR) tdo <= dr[0];
                else                       tdo <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtag_clk_tap.sv
// Bench for jtag_clk_tap: bit-bangs tck/tms/tdi, models the register bus, and
// compares shifted-out tdo bits against an expected-bit queue.
module tb_jtag_clk_tap;

    localparam int IR_W  = 5;
    localparam int DR_W  = 96;
    localparam int LEN_W = 7;
    localparam int ID_W  = 40;
    localparam int HALF  = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tck = 1'b0;
    logic             tms = 1'b0;
    logic             tdi = 1'b0;
    logic             tdo;
    logic [ID_W-1:0]  id = 40'h12_3456_789A;
    logic [IR_W-1:0]  ir;
    logic [3:0]       jstate;
    logic             reg_rd_req;
    logic             reg_rd_ack = 1'b0;
    logic [DR_W-1:0]  reg_rd_data = '0;
    logic [LEN_W-1:0] reg_len = '0;
    logic             reg_wr_stb;
    logic [DR_W-1:0]  reg_wr_data;
    logic             capture_err;

    int vectors     = 0;
    int miscompares = 0;
    logic exp_q[$];

    int              wr_cnt = 0;
    int              rd_cnt = 0;
    logic [IR_W-1:0] wr_ir  = '0;
    logic [DR_W-1:0] wr_seen = '0;

    logic             bus_en    = 1'b1;
    int               bus_delay = 2;
    logic [DR_W-1:0]  bus_data  = '0;
    logic [LEN_W-1:0] bus_len   = '0;

    jtag_clk_tap dut (
        .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
        .id(id), .ir(ir), .jstate(jstate),
        .reg_rd_req(reg_rd_req), .reg_rd_ack(reg_rd_ack), .reg_rd_data(reg_rd_data),
        .reg_len(reg_len), .reg_wr_stb(reg_wr_stb), .reg_wr_data(reg_wr_data),
        .capture_err(capture_err)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts strobes and records what the bus saw at each write.
    always @(negedge clk) begin
        if (reg_wr_stb) begin
            wr_cnt++;
            wr_ir   = ir;
            wr_seen = reg_wr_data;
        end
        if (reg_rd_req) rd_cnt++;
    end

    // Register-bus model: answers each request after bus_delay clks unless disabled.
    initial begin
        forever begin
            @(negedge clk);
            if (reg_rd_req && bus_en) begin
                repeat (bus_delay) @(negedge clk);
                reg_rd_data = bus_data;
                reg_len     = bus_len;
                reg_rd_ack  = 1'b1;
                @(negedge clk);
                reg_rd_ack  = 1'b0;
                reg_rd_data = '0;
            end
        end
    end

    task automatic pulse(input logic tms_v, input logic tdi_v, output logic tdo_v);
        tms = tms_v;
        tdi = tdi_v;
        repeat (HALF) @(negedge clk);
        tck = 1'b1;
        repeat (HALF) @(negedge clk);
        tck = 1'b0;
        repeat (HALF) @(negedge clk);
        tdo_v = tdo;
    endtask

    task automatic reset_dut();
        tck = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic shift_ir(input logic [IR_W-1:0] instr, output logic [IR_W-1:0] prev);
        logic t;
        pulse(1'b1, 1'b0, t);
        pulse(1'b1, 1'b0, t);
        pulse(1'b0, 1'b0, t);
        pulse(1'b0, 1'b0, t);
        prev[0] = t;
        for (int i = 0; i < IR_W; i++) begin
            pulse(i == IR_W - 1, instr[i], t);
            if (i < IR_W - 1) prev[i+1] = t;
        end
        pulse(1'b1, 1'b0, t);
        pulse(1'b0, 1'b0, t);
    endtask

    task automatic scan_dr(input int n, input logic [DR_W-1:0] din, output logic [DR_W-1:0] dout);
        logic t;
        dout = '0;
        pulse(1'b1, 1'b0, t);
        pulse(1'b0, 1'b0, t);
        pulse(1'b0, 1'b0, t);
        dout[0] = t;
        for (int i = 0; i < n; i++) begin
            pulse(i == n - 1, din[i], t);
            if (i < n - 1) dout[i+1] = t;
        end
        pulse(1'b1, 1'b0, t);
        pulse(1'b0, 1'b0, t);
    endtask

    task automatic test_reset();
        logic t;
        reset_dut();
        vectors++;
        if (jstate !== 4'hF) begin miscompares++; $display("[TB] FAIL reset_jstate: got %h expected %h", jstate, 4'hF); end
        vectors++;
        if (ir !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_ir: got %0d expected 0", ir); end
        vectors++;
        if (tdo !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tdo: got %b expected 0", tdo); end
        vectors++;
        if (capture_err !== 1'b0 || reg_wr_data !== '0) begin
            miscompares++; $display("[TB] FAIL reset_bus: got err=%b wr_data=%h expected 0/0", capture_err, reg_wr_data);
        end
        pulse(1'b0, 1'b0, t);
        vectors++;
        if (jstate !== 4'hE) begin miscompares++; $display("[TB] FAIL rti_jstate: got %h expected %h", jstate, 4'hE); end
    endtask

    task automatic test_idcode();
        logic [DR_W-1:0] dout;
        logic            e;
        int              rc0, wc0;
        rc0 = rd_cnt;
        wc0 = wr_cnt;
        for (int i = 0; i < ID_W; i++) exp_q.push_back(id[i]);
        scan_dr(ID_W, '0, dout);
        for (int i = 0; i < ID_W; i++) begin
            e = exp_q.pop_front();
            vectors++;
            if (dout[i] !== e) begin miscompares++; $display("[TB] FAIL idcode_bit%0d: got %b expected %b", i, dout[i], e); end
        end
        vectors++;
        if (rd_cnt !== rc0 || wr_cnt !== wc0) begin
            miscompares++; $display("[TB] FAIL idcode_bus: got rd=%0d wr=%0d expected rd=%0d wr=%0d", rd_cnt, wr_cnt, rc0, wc0);
        end
    endtask

    task automatic test_user_write();
        logic [DR_W-1:0] dout;
        logic [IR_W-1:0] prev;
        logic [8:0]      cap = 9'h0A5;
        logic            e;
        int              rc0, wc0;
        bus_en   = 1'b1;
        bus_data = 96'hFFFF_0000_0000_0000_0000_00A5;
        bus_len  = 7'd9;
        shift_ir(5'd22, prev);
        vectors++;
        if (prev !== 5'd0) begin miscompares++; $display("[TB] FAIL user_ir_capture: got %0d expected 0", prev); end
        rc0 = rd_cnt;
        wc0 = wr_cnt;
        for (int i = 0; i < 9; i++) exp_q.push_back(cap[i]);
        scan_dr(9, 96'h1FD, dout);
        for (int i = 0; i < 9; i++) begin
            e = exp_q.pop_front();
            vectors++;
            if (dout[i] !== e) begin miscompares++; $display("[TB] FAIL user_cap_bit%0d: got %b expected %b", i, dout[i], e); end
        end
        vectors++;
        if (wr_cnt !== wc0 + 1 || rd_cnt !== rc0 + 1) begin
            miscompares++; $display("[TB] FAIL user_strobes: got wr=%0d rd=%0d expected wr=%0d rd=%0d", wr_cnt, rd_cnt, wc0 + 1, rc0 + 1);
        end
        vectors++;
        if (wr_ir !== 5'd22) begin miscompares++; $display("[TB] FAIL user_wr_ir: got %0d expected 22", wr_ir); end
        vectors++;
        if (wr_seen !== 96'h1FD) begin miscompares++; $display("[TB] FAIL user_wr_data: got %h expected %h", wr_seen, 96'h1FD); end
        vectors++;
        if (capture_err !== 1'b0) begin miscompares++; $display("[TB] FAIL user_err: got %b expected 0", capture_err); end
    endtask

    task automatic test_capture_err();
        logic [DR_W-1:0] dout;
        logic [IR_W-1:0] prev;
        logic [DR_W-1:0] din = 96'hDEAD_BEEF_0123_4567_89AB_CDEF;
        logic [15:0]     cap = 16'hBEEF;
        logic            e;
        shift_ir(5'd21, prev);
        vectors++;
        if (prev !== 5'd22) begin miscompares++; $display("[TB] FAIL err_ir_capture: got %0d expected 22", prev); end
        bus_en = 1'b0;
        for (int i = 0; i < DR_W; i++) exp_q.push_back(1'b0);
        scan_dr(DR_W, din, dout);
        for (int i = 0; i < DR_W; i++) begin
            e = exp_q.pop_front();
            vectors++;
            if (dout[i] !== e) begin miscompares++; $display("[TB] FAIL noack_bit%0d: got %b expected %b", i, dout[i], e); end
        end
        vectors++;
        if (capture_err !== 1'b1) begin miscompares++; $display("[TB] FAIL noack_err: got %b expected 1", capture_err); end
        vectors++;
        if (wr_seen !== din) begin miscompares++; $display("[TB] FAIL noack_wr_data: got %h expected %h", wr_seen, din); end
        bus_en   = 1'b1;
        bus_data = 96'hBEEF;
        bus_len  = 7'd16;
        for (int i = 0; i < 16; i++) exp_q.push_back(cap[i]);
        scan_dr(16, 96'h1234, dout);
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            vectors++;
            if (dout[i] !== e) begin miscompares++; $display("[TB] FAIL ack_bit%0d: got %b expected %b", i, dout[i], e); end
        end
        vectors++;
        if (capture_err !== 1'b1) begin miscompares++; $display("[TB] FAIL sticky_err: got %b expected 1", capture_err); end
        vectors++;
        if (wr_seen !== 96'h1234) begin miscompares++; $display("[TB] FAIL ack_wr_data: got %h expected %h", wr_seen, 96'h1234); end
    endtask

    task automatic test_bypass();
        logic [DR_W-1:0] dout;
        logic [IR_W-1:0] prev;
        logic [7:0]      din = 8'hC3;
        logic            e;
        int              rc0, wc0;
        shift_ir(5'h1F, prev);
        vectors++;
        if (prev !== 5'd21) begin miscompares++; $display("[TB] FAIL bypass_ir_capture: got %0d expected 21", prev); end
        rc0 = rd_cnt;
        wc0 = wr_cnt;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 7; i++) exp_q.push_back(din[i]);
        scan_dr(8, DR_W'(din), dout);
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            vectors++;
            if (dout[i] !== e) begin miscompares++; $display("[TB] FAIL bypass_bit%0d: got %b expected %b", i, dout[i], e); end
        end
        vectors++;
        if (rd_cnt !== rc0 || wr_cnt !== wc0) begin
            miscompares++; $display("[TB] FAIL bypass_bus: got rd=%0d wr=%0d expected rd=%0d wr=%0d", rd_cnt, wr_cnt, rc0, wc0);
        end
        vectors++;
        if (reg_wr_data !== 96'h1234) begin miscompares++; $display("[TB] FAIL wr_data_hold: got %h expected %h", reg_wr_data, 96'h1234); end
    endtask

    task automatic test_reset_abort();
        logic [IR_W-1:0] prev;
        logic            t;
        int              wc0;
        bus_en   = 1'b1;
        bus_data = 96'h3;
        bus_len  = 7'd4;
        shift_ir(5'd22, prev);
        vectors++;
        if (prev !== 5'h1F) begin miscompares++; $display("[TB] FAIL abort_ir_capture: got %0d expected 31", prev); end
        wc0 = wr_cnt;
        pulse(1'b1, 1'b0, t);
        pulse(1'b0, 1'b0, t);
        pulse(1'b0, 1'b0, t);
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, t);
        reset_dut();
        repeat (20) @(negedge clk);
        vectors++;
        if (wr_cnt !== wc0) begin miscompares++; $display("[TB] FAIL abort_no_wr: got %0d expected %0d", wr_cnt, wc0); end
        vectors++;
        if (jstate !== 4'hF || ir !== 5'd0 || tdo !== 1'b0) begin
            miscompares++; $display("[TB] FAIL abort_state: got jstate=%h ir=%0d tdo=%b expected F/0/0", jstate, ir, tdo);
        end
    endtask

    task automatic test_tms_reset();
        logic [IR_W-1:0] prev;
        logic            t;
        pulse(1'b0, 1'b0, t);
        shift_ir(5'd22, prev);
        vectors++;
        if (ir !== 5'd22) begin miscompares++; $display("[TB] FAIL tms_ir_loaded: got %0d expected 22", ir); end
        pulse(1'b1, 1'b0, t);
        pulse(1'b1, 1'b0, t);
        pulse(1'b0, 1'b0, t);
        pulse(1'b0, 1'b0, t);
        pulse(1'b0, 1'b1, t);
        vectors++;
        if (jstate !== ~4'd11) begin miscompares++; $display("[TB] FAIL tms_in_shir: got %h expected %h", jstate, ~4'd11); end
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, t);
        vectors++;
        if (jstate !== 4'hF) begin miscompares++; $display("[TB] FAIL tms_tlr: got %h expected %h", jstate, 4'hF); end
        vectors++;
        if (ir !== 5'd0) begin miscompares++; $display("[TB] FAIL tms_ir_reset: got %0d expected 0", ir); end
    endtask

    initial begin
        test_reset();
        test_idcode();
        test_user_write();
        test_capture_err();
        test_bypass();
        test_reset_abort();
        test_tms_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
